// File: rtl/mult_scheduler.sv
// Two-requester shift-and-add multiplier: round-robin grant in IDLE, one
// multiplier bit per CALC cycle, result held in DONE until consumed.
module mult_scheduler #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [M-1:0]     a0,
    input  logic [M-1:0]     a1,
    input  logic [N-1:0]     b0,
    input  logic [N-1:0]     b1,
    output logic [1:0]       req_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [M+N-1:0]   res_data,
    output logic             res_id,
    output logic             busy
);

    localparam int W  = M + N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           last_r;
    logic [W-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [W-1:0]   acc_r;
    logic [CW-1:0]  cnt_r;
    logic           id_r;
    logic [1:0]     grant_s;
    logic           accept_s;
    logic           last_bit_s;
    logic [W-1:0]   addend_s;

    // Round-robin arbiter: on a tie, the requester not granted last wins.
    always_comb begin
        grant_s = 2'b00;
        if (rst || (state_r != IDLE)) begin
            grant_s = 2'b00;
        end else begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end
    end

    assign req_ready  = grant_s;
    assign accept_s   = |(req_valid & grant_s);
    assign last_bit_s = (cnt_r == CW'(N - 1));
    assign addend_s   = b_r[cnt_r] ? (a_r << cnt_r) : {W{1'b0}};

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = CALC;
                else          state_nxt_s = IDLE;
            end
            CALC: begin
                if (last_bit_s) state_nxt_s = DONE;
                else            state_nxt_s = CALC;
            end
            DONE: begin
                if (res_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, accumulation and grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
            a_r    <= {W{1'b0}};
            b_r    <= {N{1'b0}};
            acc_r  <= {W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            id_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r    <= grant_s[1] ? {{N{1'b0}}, a1} : {{N{1'b0}}, a0};
                        b_r    <= grant_s[1] ? b1 : b0;
                        id_r   <= grant_s[1];
                        last_r <= grant_s[1];
                        acc_r  <= {W{1'b0}};
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                CALC: begin
                    acc_r <= acc_r + addend_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Outputs are direct decodes of registered state.
    assign res_valid = (state_r == DONE);
    assign res_data  = acc_r;
    assign res_id    = id_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter M, default 4: width of operand A.
REQ-002 Parameter N, default 4: width of operand B and number of iteration cycles.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  bit i: requester i presents an operand pair.
REQ-006 a0, a1  input  M each  operand A of requester 0 / 1.
REQ-007 b0, b1  input  N each  operand B of requester 0 / 1.
REQ-008 req_ready  output  2  bit i: requester i's pair is accepted this cycle; at most one bit high.
REQ-009 res_valid  output  1  result held on res_data/res_id.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_data  output  M+N  unsigned product A*B.
REQ-012 res_id  output  1  index of the requester that owns res_data.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CALC, DONE; there are no other states.
REQ-015 req_ready SHALL be combinational and is nonzero only in IDLE.
REQ-016 In IDLE, a single valid requester SHALL be granted.
REQ-017 In IDLE, with both valid, the requester not granted most recently SHALL be granted (round-robin).
REQ-018 The last-grant pointer SHALL update only on an accepted request.
REQ-019 Accept = req_valid[i] & req_ready[i] at a rising edge.
REQ-020 On accept, the block SHALL capture A, zero-extended to M+N bits, and B, record id=i, clear the accumulator, clear bit counter i_cnt, and go to CALC.
REQ-021 Operand changes after the accept edge SHALL have no effect on the result.
REQ-022 CALC SHALL process one multiplier bit per cycle, LSB first: if B[i_cnt], acc += (A << i_cnt), all in M+N bits with no overflow possible.
REQ-023 CALC SHALL last exactly N cycles; on the edge that processes bit N-1, the FSM SHALL go to DONE with res_valid=1.
REQ-024 Latency: with the accept at edge E, res_valid SHALL first be high after edge E+N.
REQ-025 In DONE, res_valid, res_data and res_id SHALL hold stable until res_ready=1 at an edge.
REQ-026 That res_ready edge SHALL return the FSM to IDLE and deassert res_valid.
REQ-027 A new request SHALL be accepted no earlier than the first IDLE cycle after the result is consumed.
REQ-028 res_ready outside DONE SHALL be ignored.
REQ-029 res_data outside DONE is don't-care for checking but SHALL NOT be X after reset.
REQ-030 Operand zero (A=0 or B=0) SHALL still take N CALC cycles, with res_data=0.
REQ-031 Maximum operands SHALL yield the exact product, e.g. M=N=4: 15*15=225.
REQ-032 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, res_valid=0, res_data=0, res_id=0, accumulator=0, i_cnt=0, busy=0.
REQ-034 rst=1 at an edge SHALL set the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-035 rst SHALL take priority over every other event, including an accept or res_ready at the same edge.
REQ-036 rst during CALC or DONE SHALL abort the operation silently; no res_valid is produced for it.
REQ-037 While rst=1, req_ready SHALL be 0.

Verification (M=N=4)
REQ-038 Single request: req0 a0=3, b0=5, accepted at E -> res_valid after E+4, res_data=15, res_id=0, busy high E..consume.
REQ-039 Tie after reset: both valid (a0=2,b0=3; a1=4,b1=4), res_ready held 1 -> first res_id=0 res_data=6, then res_id=1 res_data=16.
REQ-040 Round-robin: both valid continuously for 4 transactions -> res_id sequence 0,1,0,1.
REQ-041 Backpressure: res_ready=0 for 7 cycles after res_valid -> res_data and res_id stable, req_ready=2'b00 throughout, accept only after consume.
REQ-042 Boundaries: 15*15 -> 225; 0*9 -> 0 after exactly 4 CALC cycles; operands changed mid-CALC -> result unchanged.
REQ-043 Reset mid-CALC: rst asserted 2 cycles after accept -> IDLE next edge, no res_valid; the next tie is granted to requester 0.
